// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_pkg
// Description : Shared exception-controller types, cause codes and default
//               exception vector (also used by maindec).
// Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } exc_state_t;

    localparam logic [3:0]  ESTAT_NONE     = 4'b0000;
    localparam logic [3:0]  ESTAT_IRQ      = 4'b0001;
    localparam logic [3:0]  ESTAT_INVOP    = 4'b0010;
    localparam logic [63:0] DEFAULT_VECTOR = 64'hD8;

endpackage : exc_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational priority encoder, lowest set request wins.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0]         req,
    output logic                     valid,
    output logic [$clog2(N_IRQ)-1:0] idx
);

    localparam int IW = $clog2(N_IRQ);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Edge-latched, maskable, prioritised interrupt and invalid-op
//               exception controller holding handler state, ELR and EStatus.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int             N_IRQ  = 4,
    parameter int             N      = 64,
    parameter logic [N-1:0]   VECTOR = DEFAULT_VECTOR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IRQ-1:0]         ExtIRQ,
    input  logic                     MaskWe,
    input  logic [N_IRQ-1:0]         MaskIn,
    input  logic                     InvalidOp,
    input  logic                     ERet,
    input  logic [N-1:0]             PC,
    input  logic [N-1:0]             NextPC,
    output logic                     Exc,
    output logic [N-1:0]             ExcVector,
    output logic [3:0]               EStatus,
    output logic [N-1:0]             ELR,
    output logic [$clog2(N_IRQ)-1:0] IrqId,
    output logic [N_IRQ-1:0]         Pending,
    output logic [N_IRQ-1:0]         IrqMask,
    output logic                     InHandler,
    output logic                     Halt
);

    localparam int IW = $clog2(N_IRQ);

    exc_state_t         r_state;
    exc_state_t         w_state_next;
    logic [N_IRQ-1:0]   r_prev;
    logic [N_IRQ-1:0]   r_pending;
    logic [N_IRQ-1:0]   r_mask;
    logic [3:0]         r_estatus;
    logic [N-1:0]       r_elr;
    logic [IW-1:0]      r_irq_id;

    logic [N_IRQ-1:0]   w_edge;
    logic [N_IRQ-1:0]   w_req;
    logic               w_req_valid;
    logic [IW-1:0]      w_req_idx;
    logic               w_take_irq;
    logic               w_take_invop;
    logic [N_IRQ-1:0]   w_take_vec;

    assign w_edge = ExtIRQ & ~r_prev;
    assign w_req  = r_pending & ~r_mask;

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req   (w_req),
        .valid (w_req_valid),
        .idx   (w_req_idx)
    );

    always_comb begin
        w_state_next = r_state;
        Exc          = 1'b0;
        w_take_irq   = 1'b0;
        w_take_invop = 1'b0;
        case (r_state)
            RUN: begin
                if (InvalidOp) begin
                    Exc          = 1'b1;
                    w_take_invop = 1'b1;
                    w_state_next = HANDLER;
                end else if (w_req_valid) begin
                    Exc          = 1'b1;
                    w_take_irq   = 1'b1;
                    w_state_next = HANDLER;
                end
            end
            HANDLER: begin
                // A fault inside the handler is unrecoverable, even alongside ERET.
                if (InvalidOp) begin
                    Exc          = 1'b1;
                    w_state_next = HALT;
                end else if (ERet) begin
                    w_state_next = RUN;
                end
            end
            HALT: begin
                Exc = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign w_take_vec = w_take_irq ? (N_IRQ'(1) << w_req_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_estatus <= ESTAT_NONE;
            r_elr     <= '0;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_prev    <= ExtIRQ;
            r_pending <= (r_pending & ~w_take_vec) | w_edge;
            if (MaskWe) begin
                r_mask <= MaskIn;
            end
            if (w_take_invop) begin
                r_estatus <= ESTAT_INVOP;
                r_elr     <= NextPC;
            end else if (w_take_irq) begin
                // The interrupted instruction is squashed, so it is re-executed on return.
                r_estatus <= ESTAT_IRQ;
                r_elr     <= PC;
                r_irq_id  <= w_req_idx;
            end
        end
    end

    assign ExcVector = VECTOR;
    assign EStatus   = r_estatus;
    assign ELR       = r_elr;
    assign IrqId     = r_irq_id;
    assign Pending   = r_pending;
    assign IrqMask   = r_mask;
    assign InHandler = (r_state == HANDLER);
    assign Halt      = (r_state == HALT);

endmodule : exc_ctrl
`default_nettype wire
